// File: rtl/if_prefetch_queue_pkg.sv
// Purpose: shared constants and entry type for the instruction prefetch queue.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package if_prefetch_queue_pkg;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction presented when the queue is empty (encodes as a NOP downstream).
  localparam logic [31:0] NOP = 32'h0000_0000;

  // One prefetched instruction together with the address of its successor.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } entry_t;

  // Sequential successor; the 32-bit add wraps, so 0xFFFF_FFFC -> 0.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Instructions are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Purpose: circular storage and head/tail pointers for prefetched instruction entries.
// Latency: head entry readable combinationally; a push is visible at the head after the edge it is written on.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
//
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   push, pop       - write one entry at the tail / retire the head entry
//   flush           - empty the queue (pointers and count to zero); dominates push/pop
//   wrData          - entry written at the tail on push
//   rdData          - raw head entry (undefined content while count == 0)
//   count           - occupancy, 0..DEPTH
module prefetch_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wrData,
  output entry_t        rdData,
  output logic [CW-1:0] count
);

  // Storage is deliberately left unreset; the top masks it while count == 0.
  entry_t        storage [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;

  // DEPTH is a power of two, so natural pointer overflow gives modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PW'(1);
      if (pop)  headPtr <= headPtr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // When full with a simultaneous pop, tailPtr == headPtr: the old head is read
  // combinationally this cycle and overwritten at the edge, which is intended.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[tailPtr] <= wrData;
  end

  assign rdData = storage[headPtr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Purpose: instruction-fetch prefetch queue: drives the fetch address and buffers fetched words for IF/ID.
// Latency: a word fetched on edge N is at the head after edge N if the queue was empty; no ImemData bypass.
// Backpressure: Stall holds the head; fetching continues until DEPTH entries are buffered, then FetchPC holds.
//
// Ports:
//   Clk, Rst               - clock and asynchronous active-high reset
//   Redirect, RedirectAddr - taken branch/jump from decode; flushes the queue and retargets fetch
//   Stall                  - hazard hold; the head entry is not consumed
//   ImemAddr, ImemData     - combinational instruction memory interface
//   Instruction, PCPlus4   - head entry to IF/ID (NOP / 0 when empty)
//   Valid, Count           - head-holds-instruction flag and current occupancy
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter  int          DEPTH    = DEFAULT_DEPTH,
  parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Redirect,
  input  logic [31:0]   RedirectAddr,
  input  logic          Stall,
  output logic [31:0]   ImemAddr,
  input  logic [31:0]   ImemData,
  output logic [31:0]   Instruction,
  output logic [31:0]   PCPlus4,
  output logic          Valid,
  output logic [CW-1:0] Count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0] fetchPc;
  logic        push;
  logic        pop;
  logic        full;
  entry_t      fillEntry;
  entry_t      headEntry;

  assign full  = (Count == FULL_COUNT);
  assign Valid = (Count != '0);

  // Redirect squashes both directions of traffic and overrides Stall.
  assign pop  = Valid && !Stall && !Redirect;
  // A full queue may still accept a word when the head retires this cycle.
  assign push = !Redirect && (!full || pop);

  assign fillEntry = '{instr: ImemData, pcplus4: nextPc(fetchPc)};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetchPc <= RESET_PC;
    end else if (Redirect) begin
      fetchPc <= alignPc(RedirectAddr);
    end else if (push) begin
      fetchPc <= nextPc(fetchPc);
    end
  end

  assign ImemAddr = fetchPc;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (Clk),
    .rst    (Rst),
    .push   (push),
    .pop    (pop),
    .flush  (Redirect),
    .wrData (fillEntry),
    .rdData (headEntry),
    .count  (Count)
  );

  // Unreset storage must never leak out, so the head is masked while empty.
  assign Instruction = Valid ? headEntry.instr   : NOP;
  assign PCPlus4     = Valid ? headEntry.pcplus4 : 32'h0000_0000;

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] SCRAMBLE = 32'h5A5A_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        Stall;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic [2:0]  Count;
  logic        memMode;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Memory: identity (word at address i is i) or a scrambled variant.
  assign ImemData = memMode ? (ImemAddr ^ SCRAMBLE) : ImemAddr;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
    .Stall(Stall), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .Instruction(Instruction), .PCPlus4(PCPlus4), .Valid(Valid), .Count(Count)
  );

  // ---------------- reference model: a plain queue of fetched words --------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mPc;

  function automatic logic [31:0] memRef(input logic [31:0] a);
    return memMode ? (a ^ SCRAMBLE) : a;
  endfunction

  task automatic modelReset();
    mq.delete();
    mPc = RESET_PC;
  endtask

  task automatic modelStep(input logic r, input logic [31:0] a, input logic s);
    int    n;
    bit    doPop;
    bit    doPush;
    ment_t e;
    n = mq.size();
    if (r) begin
      mq.delete();
      mPc = a & 32'hFFFF_FFFC;
    end else begin
      doPop  = (n > 0) && !s;
      doPush = (n < DEPTH) || doPop;
      if (doPop) void'(mq.pop_front());
      if (doPush) begin
        e.instr = memRef(mPc);
        e.pc4   = mPc + 32'd4;
        mq.push_back(e);
        mPc = mPc + 32'd4;
      end
    end
  endtask

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input int unsigned eCnt, input logic eV,
                          input logic [31:0] eI, input logic [31:0] eP, input logic [31:0] eA);
    chk({tag, " Count"},       32'(Count),  eCnt);
    chk({tag, " Valid"},       32'(Valid),  32'(eV));
    chk({tag, " Instruction"}, Instruction, eI);
    chk({tag, " PCPlus4"},     PCPlus4,     eP);
    chk({tag, " ImemAddr"},    ImemAddr,    eA);
  endtask

  task automatic checkModel(input string tag);
    if (mq.size() != 0)
      checkOut(tag, mq.size(), 1'b1, mq[0].instr, mq[0].pc4, mPc);
    else
      checkOut(tag, 0, 1'b0, 32'h0, 32'h0, mPc);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Called at posedge+1; reset is pulsed entirely between edges.
  task automatic applyReset();
    Rst = 1'b1;
    #2;
    Rst = 1'b0;
  endtask

  // ---------------- directed vector table (identity memory) ----------------
  typedef struct {
    logic        redirect;
    logic [31:0] raddr;
    logic        stall;
    int unsigned eCount;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic s,
                              input int unsigned c, input logic v, input logic [31:0] i,
                              input logic [31:0] p, input logic [31:0] ad);
    vec_t x;
    x.redirect = r; x.raddr = a; x.stall = s; x.eCount = c;
    x.eValid = v; x.eInstr = i; x.ePc4 = p; x.eAddr = ad;
    return x;
  endfunction

  initial begin
    //               redir raddr          stall cnt val instr          pc4            imemAddr
    vecs[0]  = mk(0, 32'h0,          0, 1, 1, 32'h0,          32'h4,          32'h4);
    vecs[1]  = mk(0, 32'h0,          0, 1, 1, 32'h4,          32'h8,          32'h8);
    vecs[2]  = mk(0, 32'h0,          0, 1, 1, 32'h8,          32'hC,          32'hC);
    vecs[3]  = mk(0, 32'h0,          1, 2, 1, 32'h8,          32'hC,          32'h10);
    vecs[4]  = mk(0, 32'h0,          1, 3, 1, 32'h8,          32'hC,          32'h14);
    vecs[5]  = mk(0, 32'h0,          1, 4, 1, 32'h8,          32'hC,          32'h18);
    vecs[6]  = mk(0, 32'h0,          1, 4, 1, 32'h8,          32'hC,          32'h18);
    vecs[7]  = mk(0, 32'h0,          0, 4, 1, 32'hC,          32'h10,         32'h1C);
    vecs[8]  = mk(1, 32'h42,         1, 0, 0, 32'h0,          32'h0,          32'h40);
    vecs[9]  = mk(0, 32'h0,          1, 1, 1, 32'h40,         32'h44,         32'h44);
    vecs[10] = mk(0, 32'h0,          1, 2, 1, 32'h40,         32'h44,         32'h48);
    vecs[11] = mk(0, 32'h0,          0, 2, 1, 32'h44,         32'h48,         32'h4C);
    vecs[12] = mk(1, 32'hFFFF_FFF8,  0, 0, 0, 32'h0,          32'h0,          32'hFFFF_FFF8);
    vecs[13] = mk(0, 32'h0,          0, 1, 1, 32'hFFFF_FFF8,  32'hFFFF_FFFC,  32'hFFFF_FFFC);
    vecs[14] = mk(0, 32'h0,          0, 1, 1, 32'hFFFF_FFFC,  32'h0,          32'h0);
    vecs[15] = mk(0, 32'h0,          0, 1, 1, 32'h0,          32'h4,          32'h4);

    Rst = 1'b0; Redirect = 1'b0; Stall = 1'b0; RedirectAddr = 32'h0; memMode = 1'b0;
    #1 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checkOut("reset", 0, 1'b0, 32'h0, 32'h0, RESET_PC);
    Rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      Redirect     = vecs[i].redirect;
      RedirectAddr = vecs[i].raddr;
      Stall        = vecs[i].stall;
      cyc();
      checkOut($sformatf("vec%0d", i), vecs[i].eCount, vecs[i].eValid,
               vecs[i].eInstr, vecs[i].ePc4, vecs[i].eAddr);
    end
    Redirect = 1'b0;

    // Redirect to a misaligned target while three entries are buffered.
    applyReset();
    Stall = 1'b1;
    repeat (3) cyc();
    checkOut("pre-redirect", 3, 1'b1, 32'h0, 32'h4, 32'hC);
    Redirect = 1'b1; RedirectAddr = 32'h0000_0103; Stall = 1'b0;
    cyc();
    checkOut("redirect flush", 0, 1'b0, 32'h0, 32'h0, 32'h100);
    Redirect = 1'b0; Stall = 1'b1;
    cyc();
    checkOut("redirect target", 1, 1'b1, 32'h100, 32'h104, 32'h104);

    // Asynchronous reset between edges with two entries buffered.
    memMode = 1'b1;
    applyReset();
    Stall = 1'b1;
    repeat (2) cyc();
    checkOut("pre-arst", 2, 1'b1, SCRAMBLE, 32'h4, 32'h8);
    #2 Rst = 1'b1;
    #1 checkOut("arst immediate", 0, 1'b0, 32'h0, 32'h0, RESET_PC);
    Rst = 1'b0; Stall = 1'b0;
    cyc();
    checkOut("arst first head", 1, 1'b1, RESET_PC ^ SCRAMBLE, RESET_PC + 32'd4, RESET_PC + 32'd4);

    // Randomised traffic against the queue model.
    applyReset();
    modelReset();
    for (int i = 0; i < 600; i++) begin
      Redirect     = ($urandom_range(0, 15) == 0);
      Stall        = ($urandom_range(0, 2) == 0);
      RedirectAddr = $urandom;
      modelStep(Redirect, RedirectAddr, Stall);
      cyc();
      checkModel($sformatf("rnd%0d", i));
      if ($urandom_range(0, 49) == 0) begin
        Rst = 1'b1;
        #2;
        modelReset();
        checkModel($sformatf("rnd%0d arst", i));
        Rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of prefetched instruction entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port Redirect, input, 1, a taken branch or jump from the decode stage.
REQ-006 SHALL have port RedirectAddr, input, 32, the branch or jump target.
REQ-007 SHALL have port Stall, input, 1, hold from hazard detection; the head entry is not consumed.
REQ-008 SHALL have port ImemAddr, output, 32, the byte address driven to the combinational instruction memory.
REQ-009 SHALL have port ImemData, input, 32, the instruction word returned for ImemAddr in the same cycle.
REQ-010 SHALL have port Instruction, output, 32, the head instruction presented to the IF/ID register.
REQ-011 SHALL have port PCPlus4, output, 32, the head instruction's address plus 4.
REQ-012 SHALL have port Valid, output, 1, high when the head entry holds a real instruction.
REQ-013 SHALL have port Count, output, log2(DEPTH)+1, the current occupancy.

Function
REQ-014 SHALL hold a fetch register FetchPC and drive ImemAddr = FetchPC combinationally.
REQ-015 SHALL define push = !Redirect && (Count < DEPTH || pop) and pop = Valid && !Stall && !Redirect.
REQ-016 On push, SHALL write {ImemData, FetchPC+4} at the tail and set FetchPC <= FetchPC+4; the 32-bit add wraps, so 0xFFFF_FFFC becomes 0.
REQ-017 On pop, SHALL advance the head; a simultaneous push and pop SHALL leave Count unchanged, including when Count = DEPTH.
REQ-018 When Count = DEPTH and there is no pop, SHALL perform no push, hold FetchPC, and leave the stored data unchanged.
REQ-019 SHALL drive Valid = (Count != 0), and Instruction/PCPlus4 from the head entry combinationally (zero-latency read).
REQ-020 When Count = 0, SHALL drive Instruction = 32'h0000_0000 (NOP) and PCPlus4 = 0.
REQ-021 On Redirect, SHALL set Count <= 0, reset head and tail pointers, and set FetchPC <= {RedirectAddr[31:2], 2'b00}, with no push or pop that cycle; Redirect SHALL override Stall.
REQ-022 After a Redirect, the first instruction from the target SHALL be Valid at the cycle after the next rising edge.
REQ-023 Latency: an instruction fetched on edge N SHALL appear at the head on edge N if the queue was empty, otherwise behind older entries; there is no bypass of ImemData to Instruction.
REQ-024 Pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-025 While Rst=1, SHALL force FetchPC=RESET_PC, Count=0, pointers=0, Valid=0, Instruction=0, PCPlus4=0, and ImemAddr=RESET_PC, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL fetch RESET_PC.
REQ-027 Storage array contents need no reset; they SHALL never be visible while Count=0.

Structure
REQ-028 The shared package SHALL hold DEPTH, RESET_PC, the NOP constant (32'h0), and the entry typedef {instr[31:0], pcplus4[31:0]}.
REQ-029 The storage and pointers SHALL be one sub-module, prefetch_fifo (push/pop/flush, head read data, count); fetch-address control stays in the top.

Verification
REQ-030 Reset release, Stall=0, memory word at address i = i: Valid rises after the first edge; the head sequence is Instruction 0x0, 0x4, 0x8 with PCPlus4 0x4, 0x8, 0xC.
REQ-031 Stall held 6 cycles from reset: Count goes 1,2,3,4,4,4; ImemAddr holds at 0x10; the head stays 0x0; on release, consumption resumes in order with no loss.
REQ-032 Redirect with RedirectAddr=0x0000_0103 while Count=3: next cycle Count=0, Valid=0, ImemAddr=0x100; one edge later the head is Instruction=mem[0x100], PCPlus4=0x104.
REQ-033 Redirect and Stall both high while full: the queue is flushed and FetchPC=target, i.e. Redirect wins.
REQ-034 Redirect to 0xFFFF_FFF8: fetches proceed 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; PCPlus4 of the second is 0x0.
REQ-035 Rst pulsed asynchronously between edges while Count=2: Valid, Count, and Instruction go to 0 immediately; after release, the first head is mem[RESET_PC].
